hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It drives the PC and IF/ID write enables, the IF/ID flush, and the ID/EX `ControlMuxSig` (1 = pass control, 0 = insert bubble). It also produces a freeze hold for ID/EX, EX/MEM and MEM/WB while the data/video memory is not ready. It handles three cases: load-use stalls, multi-cycle stalls for `jr` on a pending register, and control-transfer flushes.

## Interface
- `MEM_TIMEOUT`, 255: number of consecutive not-ready memory cycles before `mem_timeout` is raised.
- `Clk` in 1: single clock; all state updates on posedge.
- `Reset` in 1: synchronous, active-high.
- `rs_address_ID`, `rt_address_ID` in 5: source registers of the instruction in ID.
- `uses_rt_ID` in 1: the ID instruction reads rt.
- `Jump_ID`, `JR_ID`, `BranchTaken_ID` in 1: control transfer resolved in ID.
- `MemRead_EX` in 2: nonzero means the EX instruction is a load.
- `RegWrite_EX` in 1: the EX instruction writes a register.
- `WriteReg_EX` in 5: destination register in EX, after the RegDst mux.
- `MemRead_MEM` in 2: nonzero means the MEM instruction is a load.
- `WriteReg_MEM` in 5: destination register in MEM.
- `mem_req_MEM` in 1: the MEM stage is accessing memory.
- `mem_ready` in 1: memory completes the access this cycle.
- `PCWrite`, `IF_ID_Write` out 1: 1 = advance.
- `IF_ID_Flush` out 1: zero the IF/ID register.
- `ControlMuxSig` out 1: 1 = pass control into ID/EX, 0 = bubble.
- `PipeHold` out 1: hold ID/EX, EX/MEM and MEM/WB.
- `mem_timeout` out 1: sticky error flag.
- `stall_cycles`, `flush_count` out 32: performance counters (see Configuration).

## Operation
- Register 0 never causes a hazard.
- Hazard terms:
  - **LU** (load-use): `MemRead_EX != 0` and `WriteReg_EX` matches `rs_address_ID`, or matches `rt_address_ID` when `uses_rt_ID` is set.
  - **JR2**: `JR_ID`, `MemRead_EX != 0`, and `WriteReg_EX == rs_address_ID`.
  - **JR1**: `JR_ID` and either `RegWrite_EX` with a match in EX, or `MemRead_MEM != 0` with `WriteReg_MEM == rs_address_ID`. JR1 applies only when JR2 is false.
  - **MW**: `mem_req_MEM` and `!mem_ready`.
- Stall length: N = 2 for JR2, 1 for JR1 or LU, 0 otherwise.
- Output classes:
  - **Freeze**: `PCWrite`=0, `IF_ID_Write`=0, `ControlMuxSig`=1, `PipeHold`=1, `IF_ID_Flush`=0.
  - **Bubble**: `PCWrite`=0, `IF_ID_Write`=0, `ControlMuxSig`=0, `PipeHold`=0, `IF_ID_Flush`=0.
  - **Flush**: `PCWrite`=1, `IF_ID_Write`=1, `IF_ID_Flush`=1, `ControlMuxSig`=1, `PipeHold`=0.
  - **Normal**: all enables 1, `IF_ID_Flush`=0, `PipeHold`=0.
- The FSM has states RUN, STALL and MEM_WAIT. Outputs are Mealy, decoded from the state and the current inputs. Priority is MW, then stall, then flush.
- **RUN**:
  - MW: Freeze; next state MEM_WAIT; `wait_cnt` <= 1.
  - Else N ≥ 1: Bubble. If N = 2, next state STALL with `stall_cnt` <= 1; otherwise stay in RUN.
  - Else `Jump_ID`, `JR_ID` or `BranchTaken_ID`: Flush.
  - Else: Normal.
- **STALL**:
  - MW: Freeze; next state MEM_WAIT. The remaining stall is discarded; the hazard is re-detected after release.
  - Else: Bubble; `stall_cnt` decrements; return to RUN when it reaches 0.
- **MEM_WAIT**:
  - `mem_ready` = 0: Freeze; `wait_cnt` increments and saturates.
  - `mem_ready` = 1: outputs are exactly the RUN evaluation with MW treated as false. The next state follows that RUN evaluation, so it is RUN, or STALL for JR2.
- `mem_timeout` is set on the edge where `wait_cnt` reaches `MEM_TIMEOUT`. It stays set until `Reset`. The timeout does not abort the wait.

## Timing
- Hazard response has zero latency: outputs are combinational from the state and inputs, so a hazard is acted on in the cycle it appears.
- Stall of N: exactly N consecutive Bubble cycles, then Normal. The stalled instruction issues on cycle N+1.
- Freeze lasts for every cycle with `mem_ready` = 0. Release happens in the first cycle with `mem_ready` = 1.
- While `Reset` = 1, all outputs are 0: `PCWrite`, `IF_ID_Write`, `IF_ID_Flush`, `ControlMuxSig`, `PipeHold`.
- On the edge with `Reset` = 1: state <= RUN; `stall_cnt`, `wait_cnt`, `mem_timeout` and the performance counters <= 0. A reset during STALL or MEM_WAIT aborts that state immediately.
- Simultaneous control transfer and stall: the stall wins. The flush is applied in the first cycle in which the instruction is not stalled.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every Bubble or Freeze cycle.
  - `flush_count` increments on every Flush cycle.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by `Reset`.
- `HAZ_PERF_CNT_EN` undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- `pipe_ctrl_pkg` holds:
  - the FSM state enum (RUN, STALL, MEM_WAIT);
  - the `MemRead` encodings;
  - the register-0 constant.
- Sub-module `hazard_perf_cnt` contains the two counters and is instantiated only under `HAZ_PERF_CNT_EN`.

## Test plan
- **Load-use**: `MemRead_EX`=2'b11, `WriteReg_EX`=8, `rs_address_ID`=8 -> one cycle with `PCWrite`=0, `IF_ID_Write`=0, `ControlMuxSig`=0, then Normal.
- **JR behind a load**: `JR_ID`=1, `rs_address_ID`=8, load writing 8 in EX -> exactly 2 Bubble cycles. With the load in MEM instead -> 1 Bubble cycle.
- **Register 0**: load with `WriteReg_EX`=0, `rs_address_ID`=0 -> no stall. `Jump_ID`=1 -> `IF_ID_Flush`=1 for one cycle.
- **Memory wait**: `mem_req_MEM`=1, `mem_ready` low for 3 cycles -> `PipeHold`=1 and `ControlMuxSig`=1 for 3 cycles, release on the 4th. With `HAZ_PERF_CNT_EN` defined, `stall_cycles`=3.
- **Timeout**: `MEM_TIMEOUT`=4, `mem_ready` held low -> `mem_timeout` rises after the 4th wait cycle and stays high after `mem_ready`=1.
- **Reset mid-stall**: `Reset` asserted during the second JR2 bubble -> all outputs 0 while `Reset`=1. After deassertion, Normal with no residual bubble and counters at 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Holds the FSM states, the MemRead encodings, register-0 and the output-class decode.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OC_NORMAL,
    OC_BUBBLE,
    OC_FREEZE,
    OC_FLUSH
  } out_class_t;

  localparam logic [1:0] MEMREAD_NONE = 2'b00;
  localparam logic [1:0] MEMREAD_BYTE = 2'b01;
  localparam logic [1:0] MEMREAD_HALF = 2'b10;
  localparam logic [1:0] MEMREAD_WORD = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic control_mux;
    logic pipe_hold;
  } pipe_ctrl_t;

  function automatic pipe_ctrl_t decode_class(input out_class_t cls);
    pipe_ctrl_t c;
    c = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
          control_mux: 1'b1, pipe_hold: 1'b0};
    case (cls)
      OC_BUBBLE: c = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                       control_mux: 1'b0, pipe_hold: 1'b0};
      OC_FREEZE: c = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                       control_mux: 1'b1, pipe_hold: 1'b1};
      OC_FLUSH:  c = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                       control_mux: 1'b1, pipe_hold: 1'b0};
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall and flush performance counters for hazard_ctrl.
// Built only when HAZ_PERF_CNT_EN is defined; both counters wrap modulo 2^32.
module hazard_perf_cnt (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_evt) stall_cycles <= stall_cycles + 32'd1;
      if (flush_evt) flush_count  <= flush_count + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: load-use / jr stalls, control-transfer flushes, memory freeze.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  rs_address_ID,
  input  logic [4:0]  rt_address_ID,
  input  logic        uses_rt_ID,
  input  logic        Jump_ID,
  input  logic        JR_ID,
  input  logic        BranchTaken_ID,
  input  logic [1:0]  MemRead_EX,
  input  logic        RegWrite_EX,
  input  logic [4:0]  WriteReg_EX,
  input  logic [1:0]  MemRead_MEM,
  input  logic [4:0]  WriteReg_MEM,
  input  logic        mem_req_MEM,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ControlMuxSig,
  output logic        PipeHold,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t           state, state_nxt, run_nxt;
  out_class_t       cls, run_cls;
  pipe_ctrl_t       ctrl;
  logic [1:0]       stall_cnt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             stall_load, stall_dec, wait_load, wait_inc, timeout_hit;

  // Register 0 is hardwired, so a match on it is never a dependency.
  logic rs_ex_match, rt_ex_match, rs_mem_match, load_ex, load_mem;
  logic lu, jr2, jr1, mw, xfer;

  assign rs_ex_match  = (WriteReg_EX  != REG_ZERO) && (WriteReg_EX  == rs_address_ID);
  assign rt_ex_match  = (WriteReg_EX  != REG_ZERO) && (WriteReg_EX  == rt_address_ID) && uses_rt_ID;
  assign rs_mem_match = (WriteReg_MEM != REG_ZERO) && (WriteReg_MEM == rs_address_ID);
  assign load_ex      = (MemRead_EX  != MEMREAD_NONE);
  assign load_mem     = (MemRead_MEM != MEMREAD_NONE);

  assign lu   = load_ex && (rs_ex_match || rt_ex_match);
  assign jr2  = JR_ID && load_ex && rs_ex_match;
  assign jr1  = JR_ID && !jr2 && ((RegWrite_EX && rs_ex_match) || (load_mem && rs_mem_match));
  assign mw   = mem_req_MEM && !mem_ready;
  assign xfer = Jump_ID || JR_ID || BranchTaken_ID;

  // RUN-state decision with the memory wait ignored; reused on MEM_WAIT release.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    run_cls = OC_NORMAL;
    run_nxt = ST_RUN;
    if (jr2) begin
      run_cls = OC_BUBBLE;
      run_nxt = ST_STALL;
    end else if (jr1 || lu) begin
      run_cls = OC_BUBBLE;
    end else if (xfer) begin
      run_cls = OC_FLUSH;
    end
  end

  always_comb begin
    cls        = OC_NORMAL;
    state_nxt  = state;
    stall_load = 1'b0;
    stall_dec  = 1'b0;
    wait_load  = 1'b0;
    wait_inc   = 1'b0;
    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if ((state == ST_RUN) ? mw : !mem_ready) begin
          cls       = OC_FREEZE;
          state_nxt = ST_MEM_WAIT;
          wait_load = (state == ST_RUN);
          wait_inc  = (state == ST_MEM_WAIT);
        end else begin
          cls        = run_cls;
          state_nxt  = run_nxt;
          stall_load = (run_nxt == ST_STALL);
        end
      end
      ST_STALL: begin
        if (mw) begin
          // Remaining stall is dropped; the hazard is re-detected on release.
          cls       = OC_FREEZE;
          state_nxt = ST_MEM_WAIT;
          wait_load = 1'b1;
        end else begin
          cls       = OC_BUBBLE;
          stall_dec = 1'b1;
          if (stall_cnt <= 2'd1) state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (wait_load)                             wait_cnt_nxt = WAIT_W'(1);
    else if (wait_inc && (wait_cnt != '1))     wait_cnt_nxt = wait_cnt + WAIT_W'(1);
  end

  assign timeout_hit = (wait_load || wait_inc) && (wait_cnt_nxt == WAIT_W'(MEM_TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_RUN;
      stall_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (stall_load)     stall_cnt <= 2'd1;
      else if (stall_dec) stall_cnt <= stall_cnt - 2'd1;
      if (timeout_hit)    mem_timeout <= 1'b1;
    end
  end

  assign ctrl          = Reset ? '0 : decode_class(cls);
  assign PCWrite       = ctrl.pc_write;
  assign IF_ID_Write   = ctrl.if_id_write;
  assign IF_ID_Flush   = ctrl.if_id_flush;
  assign ControlMuxSig = ctrl.control_mux;
  assign PipeHold      = ctrl.pipe_hold;

`ifdef HAZ_PERF_CNT_EN
  logic stall_evt, flush_evt;
  assign stall_evt = (cls == OC_BUBBLE) || (cls == OC_FREEZE);
  assign flush_evt = (cls == OC_FLUSH);

  hazard_perf_cnt u_perf_cnt (
    .Clk          (Clk),
    .Reset        (Reset),
    .stall_evt    (stall_evt),
    .flush_evt    (flush_evt),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
